// File: rtl/fcpu_reorder_buffer_if.sv
// Bundles the ROB's dispatch, CDB, lookup and commit signals.
// Upstream/commit logic connects through master; the ROB itself uses slave.
interface fcpu_reorder_buffer_if #(
    parameter int N_ROB_W    = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RSV_ID_W   = 5
);
    logic                  flush;
    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [2:0]            dispatch_type;
    logic [REG_ADDR_W-1:0] dispatch_dst;
    logic [N_ROB_W-1:0]    dispatch_tag;
    logic                  cdb_valid;
    logic [RSV_ID_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]     cdb_data;
    logic [N_ROB_W-1:0]    lookup_tag;
    logic                  lookup_done;
    logic [DATA_W-1:0]     lookup_data;
    logic                  commit_valid;
    logic                  commit_ready;
    logic [2:0]            commit_type;
    logic [REG_ADDR_W-1:0] commit_dst;
    logic [DATA_W-1:0]     commit_data;
    logic [N_ROB_W-1:0]    commit_tag;
    logic [N_ROB_W:0]      count;

    modport master (
        output flush, dispatch_valid, dispatch_type, dispatch_dst,
        output cdb_valid, cdb_tag, cdb_data, lookup_tag, commit_ready,
        input  dispatch_ready, dispatch_tag, lookup_done, lookup_data,
        input  commit_valid, commit_type, commit_dst, commit_data, commit_tag, count
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_type, dispatch_dst,
        input  cdb_valid, cdb_tag, cdb_data, lookup_tag, commit_ready,
        output dispatch_ready, dispatch_tag, lookup_done, lookup_data,
        output commit_valid, commit_type, commit_dst, commit_data, commit_tag, count
    );
endinterface

// File: rtl/fcpu_reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, collects CDB results,
// and retires completed entries strictly in program order.
module fcpu_reorder_buffer #(
    parameter int N_ROB_W    = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RSV_ID_W   = 5
) (
    input logic                clk,
    input logic                rstn,
    fcpu_reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << N_ROB_W;
    localparam logic [N_ROB_W:0] PTR_ONE = {{N_ROB_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [2:0]            type_q [DEPTH];
    logic [2:0]            type_d [DEPTH];
    logic [REG_ADDR_W-1:0] dst_q  [DEPTH];
    logic [REG_ADDR_W-1:0] dst_d  [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [DATA_W-1:0]     data_d [DEPTH];
    logic [N_ROB_W:0]      head_q, head_d;
    logic [N_ROB_W:0]      tail_q, tail_d;

    logic [N_ROB_W-1:0]    head_idx;
    logic [N_ROB_W-1:0]    tail_idx;
    logic [N_ROB_W-1:0]    cdb_idx;
    logic                  full;
    logic                  dispatch_fire;
    logic                  commit_fire;
    logic                  cdb_hit;

    assign head_idx = head_q[N_ROB_W-1:0];
    assign tail_idx = tail_q[N_ROB_W-1:0];
    assign cdb_idx  = rob.cdb_tag[N_ROB_W-1:0];
    // Same index with opposite wrap bits means every entry is occupied.
    assign full     = (head_idx == tail_idx) && (head_q[N_ROB_W] != tail_q[N_ROB_W]);

    assign dispatch_fire = rob.dispatch_valid && !full;
    assign commit_fire   = rob.commit_valid && rob.commit_ready;
    assign cdb_hit       = rob.cdb_valid && (rob.cdb_tag[RSV_ID_W-1:N_ROB_W] == '0)
                           && valid_q[cdb_idx];

    assign rob.dispatch_ready = !full;
    assign rob.dispatch_tag   = tail_idx;
    assign rob.count          = tail_q - head_q;
    assign rob.commit_valid   = valid_q[head_idx] && done_q[head_idx];
    assign rob.commit_type    = type_q[head_idx];
    assign rob.commit_dst     = dst_q[head_idx];
    assign rob.commit_data    = data_q[head_idx];
    assign rob.commit_tag     = head_idx;
    assign rob.lookup_done    = valid_q[rob.lookup_tag] && done_q[rob.lookup_tag];
    assign rob.lookup_data    = data_q[rob.lookup_tag];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        type_d  = type_q;
        dst_d   = dst_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (rob.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (cdb_hit) begin
                done_d[cdb_idx] = 1'b1;
                data_d[cdb_idx] = rob.cdb_data;
            end
            // Allocation is applied after the CDB update so a new entry always starts not-done.
            if (dispatch_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                type_d[tail_idx]  = rob.dispatch_type;
                dst_d[tail_idx]   = rob.dispatch_dst;
                tail_d            = tail_q + PTR_ONE;
            end
            if (commit_fire) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            type_q[i] <= type_d[i];
            dst_q[i]  <= dst_d[i];
            data_q[i] <= data_d[i];
        end
    end
endmodule

// File: tb/tb_fcpu_reorder_buffer.sv
// Scoreboard bench for fcpu_reorder_buffer: directed scenarios then random traffic,
// checked every cycle against a program-order queue model.
module tb_fcpu_reorder_buffer;
    localparam int N_ROB_W    = 4;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RSV_ID_W   = 5;
    localparam int DEPTH      = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fcpu_reorder_buffer_if #(.N_ROB_W(N_ROB_W), .DATA_W(DATA_W),
                             .REG_ADDR_W(REG_ADDR_W), .RSV_ID_W(RSV_ID_W)) bus ();

    fcpu_reorder_buffer #(.N_ROB_W(N_ROB_W), .DATA_W(DATA_W),
                          .REG_ADDR_W(REG_ADDR_W), .RSV_ID_W(RSV_ID_W)) dut (
        .clk (clk),
        .rstn(rstn),
        .rob (bus)
    );

    typedef struct {
        int                    tag;
        logic [2:0]            typ;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
        bit                    done;
    } ent_t;

    ent_t rob_q[$];      // live entries, oldest first
    int   next_tag = 0;
    int   checks   = 0;
    int   failures = 0;
    int   commits  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the model, then advances the model by what the
    // coming rising edge will do.
    always @(negedge clk) begin
        bit                 exp_cv;
        bit                 disp_ok;
        bit                 ldone;
        logic [DATA_W-1:0]  ldata;
        if (!rstn) begin
            rob_q.delete();
            next_tag = 0;
            chk("rst_count", 64'(bus.count), 64'd0);
            chk("rst_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
            chk("rst_dispatch_tag", 64'(bus.dispatch_tag), 64'd0);
            chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
            chk("rst_lookup_done", 64'(bus.lookup_done), 64'd0);
        end else begin
            exp_cv = (rob_q.size() > 0) && rob_q[0].done;
            chk("count", 64'(bus.count), 64'(rob_q.size()));
            chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(rob_q.size() < DEPTH));
            chk("dispatch_tag", 64'(bus.dispatch_tag), 64'(next_tag));
            chk("commit_valid", 64'(bus.commit_valid), 64'(exp_cv));
            if (exp_cv) begin
                chk("commit_tag", 64'(bus.commit_tag), 64'(rob_q[0].tag));
                chk("commit_type", 64'(bus.commit_type), 64'(rob_q[0].typ));
                chk("commit_dst", 64'(bus.commit_dst), 64'(rob_q[0].dst));
                chk("commit_data", 64'(bus.commit_data), 64'(rob_q[0].data));
            end
            ldone = 1'b0;
            ldata = '0;
            foreach (rob_q[i]) begin
                if (rob_q[i].tag == int'(bus.lookup_tag)) begin
                    ldone = rob_q[i].done;
                    ldata = rob_q[i].data;
                end
            end
            chk("lookup_done", 64'(bus.lookup_done), 64'(ldone));
            if (ldone) chk("lookup_data", 64'(bus.lookup_data), 64'(ldata));

            if (bus.flush) begin
                rob_q.delete();
                next_tag = 0;
            end else begin
                disp_ok = rob_q.size() < DEPTH;
                if (bus.cdb_valid && int'(bus.cdb_tag) < DEPTH) begin
                    foreach (rob_q[i]) begin
                        if (rob_q[i].tag == int'(bus.cdb_tag)) begin
                            rob_q[i].done = 1'b1;
                            rob_q[i].data = bus.cdb_data;
                        end
                    end
                end
                if (exp_cv && bus.commit_ready) begin
                    void'(rob_q.pop_front());
                    commits++;
                end
                if (bus.dispatch_valid && disp_ok) begin
                    ent_t e;
                    e.tag  = next_tag;
                    e.typ  = bus.dispatch_type;
                    e.dst  = bus.dispatch_dst;
                    e.data = '0;
                    e.done = 1'b0;
                    rob_q.push_back(e);
                    next_tag = (next_tag + 1) % DEPTH;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_type  = '0;
        bus.dispatch_dst   = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.lookup_tag     = '0;
        bus.commit_ready   = 1'b0;
    endtask

    task automatic disp(input logic [2:0] t, input logic [REG_ADDR_W-1:0] d);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_type  = t;
        bus.dispatch_dst   = d;
        tick();
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic [RSV_ID_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        int c0;
        #200_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        idle();
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Out-of-order completion, in-order retirement.
        disp(3'd1, 5'd1);
        disp(3'd2, 5'd2);
        disp(3'd3, 5'd3);
        cdb(5'd2, 32'h33);
        cdb(5'd0, 32'h11);
        cdb(5'd1, 32'h22);
        c0 = commits;
        bus.commit_ready = 1'b1;
        repeat (5) tick();
        bus.commit_ready = 1'b0;
        chk("t2_commit_total", 64'(commits - c0), 64'd3);

        // Fill to 16, free the head, wrap tag back to 0.
        do_flush();
        for (int i = 0; i < DEPTH; i++) disp(3'(i), 5'(i + 4));
        chk("t3_full_ready", 64'(bus.dispatch_ready), 64'd0);
        chk("t3_full_count", 64'(bus.count), 64'd16);
        cdb(5'd0, 32'hC0DE_0000);
        bus.commit_ready = 1'b1;
        bus.dispatch_valid = 1'b1;
        tick();
        bus.commit_ready = 1'b0;
        bus.dispatch_valid = 1'b0;
        chk("t3_ready_after_commit", 64'(bus.dispatch_ready), 64'd1);
        chk("t3_wrap_tag", 64'(bus.dispatch_tag), 64'd0);
        disp(3'd5, 5'd9);
        chk("t3_count_refilled", 64'(bus.count), 64'd16);

        // Backpressure holds the head.
        do_flush();
        disp(3'd4, 5'd7);
        cdb(5'd0, 32'hABCD_1234);
        repeat (3) tick();
        chk("t4_held_valid", 64'(bus.commit_valid), 64'd1);
        chk("t4_held_data", 64'(bus.commit_data), 64'hABCD_1234);
        c0 = commits;
        bus.commit_ready = 1'b1;
        tick();
        bus.commit_ready = 1'b0;
        tick();
        chk("t4_one_commit", 64'(commits - c0), 64'd1);

        // Flush discards live entries.
        for (int i = 0; i < 5; i++) disp(3'd2, 5'(i));
        do_flush();
        chk("t5_flush_count", 64'(bus.count), 64'd0);
        cdb(5'd3, 32'h5555);
        bus.lookup_tag = 4'd3;
        tick();
        chk("t5_lookup_after_flush", 64'(bus.lookup_done), 64'd0);
        chk("t5_tag_after_flush", 64'(bus.dispatch_tag), 64'd0);

        // Upper CDB tag bits set must be ignored.
        do_flush();
        for (int i = 0; i < 3; i++) disp(3'd1, 5'(i));
        bus.lookup_tag = 4'd2;
        cdb(5'b10010, 32'hDEAD);
        chk("t6_alias_ignored", 64'(bus.lookup_done), 64'd0);
        cdb(5'd2, 32'h6666);
        chk("t6_lookup_done", 64'(bus.lookup_done), 64'd1);
        chk("t6_lookup_data", 64'(bus.lookup_data), 64'h6666);

        // Random traffic with an asynchronous reset part-way through.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rstn = 1'b0;
                tick();
                tick();
                rstn = 1'b1;
            end
            bus.flush          = ($urandom_range(0, 63) == 0);
            bus.dispatch_valid = $urandom_range(0, 1) == 1;
            bus.dispatch_type  = 3'($urandom);
            bus.dispatch_dst   = 5'($urandom);
            bus.cdb_valid      = $urandom_range(0, 9) < 6;
            if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                bus.cdb_tag = 5'(rob_q[$urandom_range(0, rob_q.size() - 1)].tag);
            else
                bus.cdb_tag = 5'($urandom);
            bus.cdb_data       = $urandom;
            bus.lookup_tag     = 4'($urandom);
            bus.commit_ready   = $urandom_range(0, 9) < 7;
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
